// File: rtl/adc_snap_capture_ctrl_if.sv
// adc_snap_capture_ctrl_if: control, ADC stream, BRAM write port and status bundle
interface adc_snap_capture_ctrl_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int DELAY_W = 16
);
    logic               ctrl_arm;
    logic               ctrl_trig_sel;
    logic [DELAY_W-1:0] ctrl_delay;
    logic               trig_in;
    logic               din_valid;
    logic [DATA_W-1:0]  din;
    logic               bram_we;
    logic [ADDR_W-1:0]  bram_addr;
    logic [DATA_W-1:0]  bram_din;
    logic [31:0]        status_out;
    modport master (
        output ctrl_arm, ctrl_trig_sel, ctrl_delay, trig_in, din_valid, din,
        input  bram_we, bram_addr, bram_din, status_out
    );
    modport slave (
        input  ctrl_arm, ctrl_trig_sel, ctrl_delay, trig_in, din_valid, din,
        output bram_we, bram_addr, bram_din, status_out
    );
endinterface

// File: rtl/adc_snap_capture_ctrl.sv
// adc_snap_capture_ctrl: arm/trigger/delay sequencer filling the snapshot BRAM once
module adc_snap_capture_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int DELAY_W = 16
) (
    input  logic                    user_clk,
    input  logic                    user_rst,
    adc_snap_capture_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, ARMED, DELAY, CAPTURE, DONE} state_t;
    state_t state, state_n;
    logic               arm_q;
    logic [DELAY_W-1:0] dcnt;
    logic [ADDR_W-1:0]  wr_addr;
    logic [ADDR_W:0]    count;
    logic arm_re, trigger, accept;
    if (ADDR_W < 2 || ADDR_W > 16 || DATA_W < 1 || DELAY_W < 1) begin : g_bad_param
        $error("adc_snap_capture_ctrl: illegal parameter");
    end
    assign arm_re  = bus.ctrl_arm & ~arm_q;
    assign trigger = ~bus.ctrl_trig_sel | bus.trig_in;
    assign accept  = (state == CAPTURE) && bus.din_valid && !arm_re;
    always_ff @(posedge user_clk)
        if (user_rst) state <= IDLE;
        else state <= state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: state_n = arm_re ? ARMED : state;
            ARMED:      state_n = arm_re ? ARMED : !trigger ? ARMED : (bus.ctrl_delay == '0) ? CAPTURE : DELAY;
            DELAY:      state_n = arm_re ? ARMED : (bus.din_valid && dcnt == DELAY_W'(1)) ? CAPTURE : DELAY;
            CAPTURE:    state_n = arm_re ? ARMED : (accept && wr_addr == '1) ? DONE : CAPTURE;
            default:    state_n = IDLE;
        endcase
    end
    // arm_q tracks ctrl_arm even through reset so a level held across reset cannot re-arm
    always_ff @(posedge user_clk) arm_q <= bus.ctrl_arm;
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            dcnt           <= '0;
            wr_addr        <= '0;
            count          <= '0;
            bus.bram_we    <= 1'b0;
            bus.bram_addr  <= '0;
            bus.bram_din   <= '0;
            bus.status_out <= '0;
        end else begin
            bus.bram_we <= accept;
            if (accept) begin
                bus.bram_addr <= wr_addr;
                bus.bram_din  <= bus.din;
                wr_addr       <= wr_addr + ADDR_W'(1);
                count         <= count + (ADDR_W+1)'(1);
            end
            if (arm_re) begin
                wr_addr <= '0;
                count   <= '0;
                dcnt    <= '0;
            end else if (state == ARMED && state_n == DELAY) dcnt <= bus.ctrl_delay;
            else if (state == DELAY && bus.din_valid) dcnt <= dcnt - DELAY_W'(1);
            bus.status_out <= {state == DONE, state == DELAY || state == CAPTURE, state == ARMED,
                               {(28-ADDR_W){1'b0}}, count};
        end
    end
endmodule

// File: tb/tb_adc_snap_capture_ctrl.sv
// tb_adc_snap_capture_ctrl: scoreboard bench for the snapshot capture sequencer
module tb_adc_snap_capture_ctrl;
    localparam int DW = 32, AW = 4, LW = 8;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    adc_snap_capture_ctrl_if #(.DATA_W(DW), .ADDR_W(AW), .DELAY_W(LW)) bus();
    adc_snap_capture_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DELAY_W(LW)) dut (
        .user_clk(clk),
        .user_rst(rst),
        .bus(bus.slave)
    );
    typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} exp_t;
    exp_t sb[$];
    exp_t e;
    int tests = 0, fails = 0;
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic cyc(logic v, logic [DW-1:0] d);
        bus.din_valid = v;
        bus.din = d;
        @(posedge clk);
        #1;
    endtask
    task automatic push(int a, logic [DW-1:0] d);
        sb.push_back('{AW'(a), d});
    endtask
    always @(negedge clk)
        if (bus.bram_we === 1'b1) begin
            if (sb.size() == 0) check("spurious_we", 32'(bus.bram_we), 0);
            else begin
                e = sb.pop_front();
                check("wr_addr", 32'(bus.bram_addr), 32'(e.a));
                check("wr_data", bus.bram_din, e.d);
            end
        end
    initial begin
        bus.ctrl_arm = 0; bus.ctrl_trig_sel = 0; bus.ctrl_delay = 0;
        bus.trig_in = 0; bus.din_valid = 0; bus.din = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1, 32'hAAAA_0000 + i);
            check("rst_we", 32'(bus.bram_we), 0);
            check("rst_status", bus.status_out, 0);
        end
        rst = 0;
        // immediate trigger: arm edge, trigger edge, then capture every cycle
        bus.ctrl_arm = 1;
        cyc(1, 32'h100);
        cyc(1, 32'h101);
        for (int i = 0; i < 16; i++) begin
            push(i, 32'h102 + i);
            cyc(1, 32'h102 + i);
            if (i == 8) check("s1_busy", bus.status_out, 32'h4000_0008);
        end
        for (int i = 0; i < 4; i++) cyc(1, 32'hBAD0 + i);
        check("s1_done", bus.status_out, 32'h8000_0010);
        // external trigger with 5-sample delay
        bus.ctrl_arm = 0; bus.ctrl_trig_sel = 1; bus.ctrl_delay = 5;
        cyc(0, 0);
        bus.ctrl_arm = 1;
        cyc(0, 0);
        cyc(1, 32'hEE);
        check("s2_armed", bus.status_out, 32'h2000_0000);
        bus.trig_in = 1;
        cyc(1, 0);
        bus.trig_in = 0;
        for (int i = 1; i <= 5; i++) begin
            cyc(1, i);
            if (i == 3) check("s2_delay", bus.status_out, 32'h4000_0000);
        end
        for (int i = 6; i < 22; i++) begin
            push(i - 6, i);
            cyc(1, i);
            if (i == 10) check("s2_busy", 32'(bus.status_out[31:29]), 2);
        end
        bus.trig_in = 1;
        cyc(1, 32'hF00D);
        bus.trig_in = 0;
        cyc(0, 0);
        check("s2_done", bus.status_out, 32'h8000_0010);
        // gapped valid during capture
        bus.ctrl_arm = 0; bus.ctrl_trig_sel = 0; bus.ctrl_delay = 0;
        cyc(0, 0);
        bus.ctrl_arm = 1;
        cyc(0, 0);
        cyc(0, 0);
        for (int k = 0; k < 16; k++) begin
            push(k, 32'h300 + k);
            cyc(1, 32'h300 + k);
            cyc(0, 0);
            cyc(0, 0);
            if (k == 7) check("s3_count", bus.status_out, 32'h4000_0008);
        end
        check("s3_done", bus.status_out, 32'h8000_0010);
        // re-arm mid-capture after 7 samples
        bus.ctrl_arm = 0;
        cyc(0, 0);
        bus.ctrl_arm = 1;
        cyc(0, 0);
        cyc(0, 0);
        for (int i = 0; i < 7; i++) begin
            push(i, 32'h400 + i);
            cyc(1, 32'h400 + i);
        end
        bus.ctrl_trig_sel = 1; bus.ctrl_arm = 0;
        cyc(0, 0);
        bus.ctrl_arm = 1;
        cyc(0, 0);
        cyc(1, 32'h4EE);
        check("s4_rearm", bus.status_out, 32'h2000_0000);
        bus.trig_in = 1;
        cyc(1, 32'h4FF);
        bus.trig_in = 0;
        for (int i = 0; i < 16; i++) begin
            push(i, 32'h500 + i);
            cyc(1, 32'h500 + i);
        end
        cyc(0, 0);
        cyc(0, 0);
        check("s4_done", bus.status_out, 32'h8000_0010);
        // reset at sample 9 with arm held high afterwards
        bus.ctrl_arm = 0; bus.ctrl_trig_sel = 0;
        cyc(0, 0);
        bus.ctrl_arm = 1;
        cyc(0, 0);
        cyc(0, 0);
        for (int i = 0; i < 8; i++) begin
            push(i, 32'h600 + i);
            cyc(1, 32'h600 + i);
        end
        rst = 1;
        cyc(1, 32'h608);
        rst = 0;
        check("s5_rst_we", 32'(bus.bram_we), 0);
        check("s5_rst_addr", 32'(bus.bram_addr), 0);
        check("s5_rst_din", bus.bram_din, 0);
        check("s5_rst_status", bus.status_out, 0);
        for (int i = 0; i < 4; i++) cyc(1, 32'h700 + i);
        check("s5_held", bus.status_out, 0);
        bus.ctrl_arm = 0;
        cyc(0, 0);
        bus.ctrl_arm = 1;
        cyc(0, 0);
        cyc(0, 0);
        check("s5_rearm", bus.status_out, 32'h2000_0000);
        cyc(0, 0);
        cyc(0, 0);
        check("sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
